// File: rtl/scan_chain_driver.sv
// scan_chain_driver
// Drives one scan chain through a load / capture / unload sequence.
// A latched parallel pattern is shifted MSB first onto SCD, SCE is dropped
// for a programmable capture window, then the response is shifted out of
// SCO MSB first and presented on RESP_OUT together with a one-cycle DONE.
// Every output comes straight from a flop so the chain pins see clean,
// glitch-free levels for the whole cycle.

module scan_chain_driver #(
  parameter int CHAIN_LEN  = 32,
  parameter int CAP_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic                 SCO,
  output logic                 SCD,
  output logic                 SCE,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP_OUT
);

  // Counter is sized for the chain length; widened only if the capture
  // window would not fit, so the terminal compare can never be missed.
  localparam int LEN_W = $clog2(CHAIN_LEN) + 1;
  localparam int CAP_W = $clog2(CAP_CYCLES) + 1;
  localparam int CNT_W = (LEN_W > CAP_W) ? LEN_W : CAP_W;

  localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(CAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SHIFT_IN  = 3'd1;
  localparam logic [2:0] CAPTURE   = 3'd2;
  localparam logic [2:0] SHIFT_OUT = 3'd3;
  localparam logic [2:0] FINISH    = 3'd4;

  logic [2:0]           state;
  logic [2:0]           state_n;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_n;
  logic [CHAIN_LEN-1:0] pat_sh;
  logic [CHAIN_LEN-1:0] pat_n;
  logic [CHAIN_LEN-1:0] resp_sh;
  logic [CHAIN_LEN-1:0] resp_sh_n;
  logic [CHAIN_LEN-1:0] resp_out_n;
  logic                 sce_n;
  logic                 scd_n;
  logic                 busy_n;
  logic                 done_n;

  // Next-state and next-output decode; outputs are computed one cycle early
  // so that the registered pins show the value belonging to the new state.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pat_n      = pat_sh;
    resp_sh_n  = resp_sh;
    resp_out_n = RESP_OUT;
    sce_n      = 1'b0;
    scd_n      = 1'b0;
    busy_n     = 1'b0;
    done_n     = 1'b0;

    if (ABORT) begin
      // Abort beats START and leaves RESP_OUT untouched.
      state_n = IDLE;
      cnt_n   = CNT_ZERO;
    end else begin
      case (state)
        IDLE, FINISH: begin
          // FINISH accepts START too, which gives back-to-back sequences.
          if (START) begin
            state_n = SHIFT_IN;
            cnt_n   = CNT_ZERO;
            pat_n   = PAT_IN;
            sce_n   = 1'b1;
            scd_n   = PAT_IN[CHAIN_LEN-1];
            busy_n  = 1'b1;
          end else begin
            state_n = IDLE;
            cnt_n   = CNT_ZERO;
          end
        end

        SHIFT_IN: begin
          busy_n = 1'b1;
          if (cnt == LEN_LAST) begin
            state_n = CAPTURE;
            cnt_n   = CNT_ZERO;
          end else begin
            // Pattern register shifts left so the next bit is always at N-2.
            cnt_n = cnt + CNT_ONE;
            sce_n = 1'b1;
            scd_n = pat_sh[CHAIN_LEN-2];
            pat_n = {pat_sh[CHAIN_LEN-2:0], 1'b0};
          end
        end

        CAPTURE: begin
          busy_n = 1'b1;
          if (cnt == CAP_LAST) begin
            state_n = SHIFT_OUT;
            cnt_n   = CNT_ZERO;
            sce_n   = 1'b1;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end

        SHIFT_OUT: begin
          // First sample ends up in the MSB after CHAIN_LEN left shifts.
          resp_sh_n = {resp_sh[CHAIN_LEN-2:0], SCO};
          if (cnt == LEN_LAST) begin
            state_n    = FINISH;
            cnt_n      = CNT_ZERO;
            resp_out_n = resp_sh_n;
            done_n     = 1'b1;
          end else begin
            cnt_n  = cnt + CNT_ONE;
            sce_n  = 1'b1;
            busy_n = 1'b1;
          end
        end

        default: begin
          state_n = IDLE;
          cnt_n   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, datapath and output registers with asynchronous reset to idle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= CNT_ZERO;
      pat_sh   <= {CHAIN_LEN{1'b0}};
      resp_sh  <= {CHAIN_LEN{1'b0}};
      RESP_OUT <= {CHAIN_LEN{1'b0}};
      SCE      <= 1'b0;
      SCD      <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pat_sh   <= pat_n;
      resp_sh  <= resp_sh_n;
      RESP_OUT <= resp_out_n;
      SCE      <= sce_n;
      SCD      <= scd_n;
      BUSY     <= busy_n;
      DONE     <= done_n;
    end
  end

endmodule
